// File: rtl/circ_queue_if.sv
// Handshake bundle for circ_queue: enqueue/dequeue channels, flush and status flags.
// The master drives enqueue, dequeue-ready and flush; the slave (the queue) drives the rest.
interface circ_queue_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             flush;
   logic             enq_valid;
   logic             enq_ready;
   logic [WIDTH-1:0] enq_data;
   logic             deq_valid;
   logic             deq_ready;
   logic [WIDTH-1:0] deq_data;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             almost_full;

   modport master (
      output flush, enq_valid, enq_data, deq_ready,
      input  enq_ready, deq_valid, deq_data, count, empty, full, almost_full
   );

   modport slave (
      input  flush, enq_valid, enq_data, deq_ready,
      output enq_ready, deq_valid, deq_data, count, empty, full, almost_full
   );
endinterface

// File: rtl/circ_queue.sv
// Parametrised FWFT circular queue with valid/ready on both sides, arbitrary depth,
// occupancy count, almost-full threshold and synchronous flush.
module circ_queue #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = DEPTH - 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   circ_queue_if.slave   q_if
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, head_nxt;
   logic [PTR_W-1:0] tail_q, tail_d, tail_nxt;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty, full;
   logic             enq_fire, deq_fire;

   // Flags come only from registered count, so no input reaches enq_ready/deq_valid.
   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign enq_fire = q_if.enq_valid & ~full;
   assign deq_fire = ~empty & q_if.deq_ready;

   // Explicit wrap: DEPTH need not be a power of two.
   assign head_nxt = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
   assign tail_nxt = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (q_if.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq_fire) head_d = head_nxt;
         if (deq_fire) tail_d = tail_nxt;
         case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk_i) begin
      if (enq_fire && !q_if.flush) mem_q[head_q] <= q_if.enq_data;
   end

   assign q_if.enq_ready   = ~full;
   assign q_if.deq_valid   = ~empty;
   assign q_if.deq_data    = mem_q[tail_q];
   assign q_if.count       = count_q;
   assign q_if.empty       = empty;
   assign q_if.full        = full;
   assign q_if.almost_full = (count_q >= CNT_W'(AF_THRESH));

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (int'(count_q) <= int'(DEPTH))
            else $error("circ_queue: count exceeds DEPTH");
         if (count_q != '0 && !full) begin
            assert (((int'(head_q) + int'(DEPTH) - int'(tail_q)) % int'(DEPTH)) == int'(count_q))
               else $error("circ_queue: pointer distance disagrees with count");
         end
      end
   end
`endif
endmodule

// File: tb/tb_circ_queue.sv
// Self-checking bench: directed scenarios on a DEPTH=5 queue, randomized soak on a DEPTH=7
// queue against a queue-based reference model.
module tb_circ_queue;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   circ_queue_if #(.WIDTH(8), .DEPTH(5)) q5 ();
   circ_queue_if #(.WIDTH(32), .DEPTH(7)) q7 ();

   circ_queue #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3)) u_dut5 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .q_if  (q5.slave)
   );

   circ_queue #(.WIDTH(32), .DEPTH(7)) u_dut7 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .q_if  (q7.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus to the DEPTH=5 queue, then idle its inputs.
   task automatic step5(input logic ev, input logic [7:0] ed, input logic dr, input logic fl);
      q5.enq_valid = ev;
      q5.enq_data  = ed;
      q5.deq_ready = dr;
      q5.flush     = fl;
      @(posedge clk);
      #1;
      q5.enq_valid = 1'b0;
      q5.deq_ready = 1'b0;
      q5.flush     = 1'b0;
   endtask

   task automatic drain5(input string tag, input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_valid"}, 32'(q5.deq_valid), 32'd1);
         check({tag, "_data"}, 32'(q5.deq_data), 32'(first + 8'(i)));
         step5(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check({tag, "_empty"}, 32'(q5.empty), 32'd1);
   endtask

   logic [31:0] model[$];

   initial begin
      q5.enq_valid = 1'b0; q5.enq_data = '0; q5.deq_ready = 1'b0; q5.flush = 1'b0;
      q7.enq_valid = 1'b0; q7.enq_data = '0; q7.deq_ready = 1'b0; q7.flush = 1'b0;

      #2;
      check("rst_count", 32'(q5.count), 32'd0);
      check("rst_empty", 32'(q5.empty), 32'd1);
      check("rst_enq_ready", 32'(q5.enq_ready), 32'd1);
      check("rst_deq_valid", 32'(q5.deq_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Asynchronous reset mid-run, no clock edge in between.
      step5(1'b1, 8'hC1, 1'b0, 1'b0);
      step5(1'b1, 8'hC2, 1'b0, 1'b0);
      check("pre_rst_count", 32'(q5.count), 32'd2);
      rst_n = 1'b0;
      #1;
      check("async_rst_count", 32'(q5.count), 32'd0);
      check("async_rst_empty", 32'(q5.empty), 32'd1);
      check("async_rst_enq_ready", 32'(q5.enq_ready), 32'd1);
      check("async_rst_deq_valid", 32'(q5.deq_valid), 32'd0);
      check("async_rst_af", 32'(q5.almost_full), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step5(1'b0, 8'h00, 1'b1, 1'b0);
      check("idle_deq_count", 32'(q5.count), 32'd0);
      check("idle_deq_empty", 32'(q5.empty), 32'd1);

      // Fill and drain.
      for (int i = 1; i <= 5; i++) begin
         step5(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
         check("fill_count", 32'(q5.count), 32'(i));
         check("fill_af", 32'(q5.almost_full), 32'(i >= 3));
      end
      check("fill_full", 32'(q5.full), 32'd1);
      check("fill_enq_ready", 32'(q5.enq_ready), 32'd0);
      step5(1'b1, 8'h66, 1'b0, 1'b0);
      check("drop_count", 32'(q5.count), 32'd5);
      for (int i = 1; i <= 5; i++) begin
         check("drain_data", 32'(q5.deq_data), 32'(i * 8'h11));
         step5(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check("drain_empty", 32'(q5.empty), 32'd1);

      // Wrap with simultaneous enqueue and dequeue.
      for (int i = 0; i < 3; i++) step5(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         check("wrap_data", 32'(q5.deq_data), 32'(8'h80 + k));
         step5(1'b1, 8'(8'h83 + k), 1'b1, 1'b0);
         check("wrap_count", 32'(q5.count), 32'd3);
      end
      drain5("wrap_tail", 8'h8C, 3);

      // Full queue with both sides active: only the dequeue fires.
      for (int i = 1; i <= 5; i++) step5(1'b1, 8'(i), 1'b0, 1'b0);
      check("fullrd_head", 32'(q5.deq_data), 32'h01);
      step5(1'b1, 8'h06, 1'b1, 1'b0);
      check("fullrd_count", 32'(q5.count), 32'd4);
      check("fullrd_enq_ready", 32'(q5.enq_ready), 32'd1);
      drain5("fullrd", 8'h02, 4);

      // Flush discards the handshakes of its own cycle.
      for (int i = 0; i < 4; i++) step5(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
      check("flush_pre_count", 32'(q5.count), 32'd4);
      step5(1'b1, 8'h99, 1'b1, 1'b1);
      check("flush_count", 32'(q5.count), 32'd0);
      check("flush_empty", 32'(q5.empty), 32'd1);
      step5(1'b1, 8'hA5, 1'b0, 1'b0);
      check("flush_count1", 32'(q5.count), 32'd1);
      drain5("post_flush", 8'hA5, 1);

      // Random soak against the reference queue.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         int  ev_pct;
         bit  ev, dr, fl, can_enq, can_deq;
         logic [31:0] ed;
         ev_pct = ((cyc / 500) % 2 == 0) ? 75 : 35;
         ev = ($urandom_range(0, 99) < ev_pct);
         dr = ($urandom_range(0, 99) < 110 - ev_pct);
         fl = ($urandom_range(0, 99) == 0);
         ed = $urandom;

         check("soak_count", 32'(q7.count), 32'(model.size()));
         check("soak_deq_valid", 32'(q7.deq_valid), 32'(model.size() != 0));
         check("soak_enq_ready", 32'(q7.enq_ready), 32'(model.size() != 7));
         check("soak_af", 32'(q7.almost_full), 32'(model.size() >= 5));
         if (model.size() != 0) check("soak_data", q7.deq_data, model[0]);

         q7.enq_valid = ev; q7.enq_data = ed; q7.deq_ready = dr; q7.flush = fl;
         can_enq = ev && (model.size() < 7);
         can_deq = dr && (model.size() > 0);
         if (fl) begin
            model.delete();
         end else begin
            if (can_deq) void'(model.pop_front());
            if (can_enq) model.push_back(ed);
         end
         @(posedge clk);
         #1;
      end
      q7.enq_valid = 1'b0; q7.deq_ready = 1'b0; q7.flush = 1'b0;
      #1;
      check("soak_final_count", 32'(q7.count), 32'(model.size()));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/circ_queue.md
Name: circ_queue

Overview:
- Parametrised successor to the team's single-port circular queue, used as the generic buffer for OoO structures (instruction queue, fetch buffer, memory request queues).
- Adds:
  - valid/ready handshakes on both sides
  - first-word-fall-through read data
  - arbitrary (non-power-of-two) depth with explicit pointer wrap
  - simultaneous enqueue and dequeue
  - occupancy count
  - almost-full threshold
  - synchronous flush for mispredict recovery

Parameters:
- WIDTH, 32, payload width in bits.
- DEPTH, 16, number of entries; any integer >= 2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- Derived: PTR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low; state is reset while rst==0.
- flush  input  1  synchronous clear of all entries.
- enq_valid  input  1  producer offers enq_data.
- enq_ready  output  1  queue can accept; equals ~full.
- enq_data  input  WIDTH  payload to write.
- deq_valid  output  1  head entry valid; equals ~empty.
- deq_ready  input  1  consumer takes head this cycle.
- deq_data  output  WIDTH  head entry, combinational (FWFT).
- count  output  CNT_W  current occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- almost_full  output  1  count >= AF_THRESH.

Behaviour:
- Storage: DEPTH x WIDTH array. Head (write) and tail (read) pointers are PTR_W bits. Each pointer increments and wraps from DEPTH-1 to 0 explicitly, never by natural overflow.
- Memory array is not reset. Only pointers and count are reset.
- Async reset (rst==0), effective immediately without a clock edge:
  - head=0, tail=0, count=0
  - empty=1, full=0, enq_ready=1, deq_valid=0, almost_full=0
- Flags: empty, full, almost_full, enq_ready and deq_valid are pure functions of registered count. No combinational path from any input to enq_ready or deq_valid.
- Enqueue fire: enq_valid & enq_ready. mem[head] <= enq_data; head advances.
- Dequeue fire: deq_valid & deq_ready. Tail advances. deq_data = mem[tail] in the same cycle.
- Count update:
  - +1 on enqueue only
  - -1 on dequeue only
  - unchanged when both fire
- Simultaneous fire when 0<count<DEPTH: both pointers advance; count holds.
- Full: enq_ready=0 even if a dequeue fires that cycle. No same-cycle pass-through on full.
- Empty: deq_valid=0. An enqueue into an empty queue appears on deq_data/deq_valid the next cycle (latency 1, no bypass).
- deq_data is unspecified while deq_valid=0. Benches must not check it then.
- Flush (sync, highest priority): next edge sets head=tail=count=0.
  - Handshakes in the flush cycle are discarded: no write, no pointer moves.
  - Outputs in the flush cycle still reflect pre-flush state.
- Ordering: strict FIFO across any number of wraps.
- Assertions (sim only):
  - enq_valid held with stable enq_data until accepted is a producer obligation; not checked by the block.
  - count never exceeds DEPTH.
  - head - tail modulo DEPTH equals count, except when count is 0 or DEPTH.

Test Plan:
- Reset/idle (DEPTH=5, WIDTH=8): drive rst=0 mid-simulation with no clock edge -> count=0, empty=1, enq_ready=1, deq_valid=0 immediately; after release, a dequeue attempt has no effect.
- Fill/drain (DEPTH=5, AF_THRESH=3):
  - enqueue 0x11..0x55 on 5 consecutive cycles -> count steps 1..5; almost_full rises after the 3rd; full=1 and enq_ready=0 after the 5th.
  - 6th enqueue (0x66) is dropped.
  - Draining yields 0x11,0x22,0x33,0x44,0x55, then empty=1.
- Wrap with simultaneous ops (DEPTH=5): preload 3 entries, then enqueue and dequeue together for 12 cycles with incrementing data -> count stays 3 throughout; output order is exact FIFO across 2+ pointer wraps.
- Full with deq_ready (DEPTH=5): queue full, enq_valid=1 and deq_ready=1 in the same cycle -> dequeue fires, enqueue does not; count=4 next cycle; enq_ready=1.
- Flush: 4 entries held, then flush=1 with enq_valid=1, deq_ready=1 -> next cycle count=0, empty=1; neither the enqueued nor the dequeued item takes effect; a subsequent enqueue of 0xA5 is the first dequeued value.
- Random soak (DEPTH=7, WIDTH=32): 10k cycles with random valid/ready and 1% flush against a scoreboard model -> zero mismatches; count always matches the model; no assertion fires.
